// File: rtl/sb_rx_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_pkg
//  Description : Shared types and constants for the sideband receive
//                deserializer (packet width, inter-packet gap, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    localparam int SB_PKT_W  = 64;
    localparam int SB_GAP_UI = 32;

    typedef logic [63:0] sb_pkt_t;

    // Receive FSM state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        GAP  = 2'd2
    } sb_rx_state_e;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_rx_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : sb_rx_deser_if
//  Description : Valid/ready packet handoff between the sideband receive
//                deserializer (master) and the link-layer consumer (slave).
//  Signals     : pkt_data  - head-of-buffer packet        (master -> slave)
//                pkt_valid - buffer non-empty             (master -> slave)
//                pkt_ready - consumer accepts pkt_data    (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sb_rx_deser_if #(
    parameter int PKT_W = 64
) ();

    logic [PKT_W-1:0] pkt_data;
    logic             pkt_valid;
    logic             pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output pkt_ready
    );

endinterface : sb_rx_deser_if
`default_nettype wire

// File: rtl/sb_rx_deser_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_rx_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with wrapping read/write
//                pointers and an occupancy count. A push while full is
//                dropped unless a pop happens in the same cycle (pop first).
//  Ports       : clk, reset_n          - clock, async active-low reset
//                push, push_data       - write request and data
//                pop                   - read request (ignored when empty)
//                full, empty           - occupancy status
//                head_data             - entry at the read pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_rx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head_data
);

    // DEPTH is a power of two >= 2, so pointers wrap naturally on overflow
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic w_pop;
    logic w_push;

    assign full      = (count_q == COUNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    // Pop is evaluated first so a simultaneous pop frees a slot for the push
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sb_rx_fifo
`default_nettype wire

// File: rtl/sb_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sb_rx_deser
//  Description : Sideband receive deserializer. Collects PKT_W-bit packets
//                LSB-first from the sideband receiver, enforces a GAP_UI
//                minimum idle gap between packets and hands packets to the
//                link layer through a DEPTH-entry valid/ready buffer.
//  Ports       : clk, reset_n          - UI clock, async active-low reset
//                sb_bit_vld, sb_bit    - qualified sideband data bit
//                pkt_if (master)       - pkt_data / pkt_valid / pkt_ready
//                err_framing           - sticky gap violation / truncation
//                err_overflow          - sticky packet drop on full buffer
//                err_clr               - synchronous clear of both flags
//                busy                  - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_rx_deser
    import sb_pkg::*;
#(
    parameter int PKT_W  = SB_PKT_W,
    parameter int GAP_UI = SB_GAP_UI,
    parameter int DEPTH  = 2
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    input  wire logic     sb_bit_vld,
    input  wire logic     sb_bit,
    sb_rx_deser_if.master pkt_if,
    output logic          err_framing,
    output logic          err_overflow,
    input  wire logic     err_clr,
    output logic          busy
);

    localparam int CNT_W = $clog2(PKT_W);
    localparam int GAP_W = $clog2(GAP_UI + 1);

    sb_rx_state_e     state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic             err_framing_q, err_framing_d;
    logic             err_overflow_q, err_overflow_d;

    logic             w_last_bit;
    logic             w_push;
    logic [PKT_W-1:0] w_push_data;
    logic             w_framing_set;
    logic             w_overflow_set;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;

    // Final UI of a packet: the assembled word goes straight to the buffer
    assign w_last_bit  = (state_q == RECV) && sb_bit_vld
                         && (bit_cnt_q == CNT_W'(PKT_W - 1));
    assign w_push_data = {sb_bit, shift_q[PKT_W-2:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            shift_q        <= '0;
            err_framing_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            shift_q        <= shift_d;
            err_framing_q  <= err_framing_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        shift_d       = shift_q;
        w_framing_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (sb_bit_vld) begin
                    shift_d   = {{(PKT_W-1){1'b0}}, sb_bit};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = RECV;
                end
            end

            RECV: begin
                if (sb_bit_vld) begin
                    if (w_last_bit) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        shift_d[bit_cnt_q] = sb_bit;
                        bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Truncated packet: the idle UI that exposed it counts
                    // as the first gap UI.
                    w_framing_set = 1'b1;
                    bit_cnt_d     = '0;
                    gap_cnt_d     = GAP_W'(1);
                    state_d       = GAP;
                end
            end

            GAP: begin
                if (sb_bit_vld) begin
                    // Gap too short: flag it but still receive the packet
                    w_framing_set = 1'b1;
                    shift_d       = {{(PKT_W-1){1'b0}}, sb_bit};
                    bit_cnt_d     = CNT_W'(1);
                    state_d       = RECV;
                end else begin
                    if (gap_cnt_q < GAP_W'(GAP_UI)) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                    // Leaving as the count reaches GAP_UI lets the next UI
                    // (GAP_UI+1 after the last bit) start a packet in IDLE.
                    if (gap_cnt_d == GAP_W'(GAP_UI)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase

        // Sticky flags: a new event in the same cycle as err_clr wins
        err_framing_d  = (err_framing_q  & ~err_clr) | w_framing_set;
        err_overflow_d = (err_overflow_q & ~err_clr) | w_overflow_set;
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy           = (state_q != IDLE);
        w_push         = w_last_bit;
        w_pop          = pkt_if.pkt_valid & pkt_if.pkt_ready;
        // A pop in the same cycle makes room, so only a blocked push drops
        w_overflow_set = w_push & w_fifo_full & ~w_pop;
        err_framing    = err_framing_q;
        err_overflow   = err_overflow_q;
    end

    assign pkt_if.pkt_valid = ~w_fifo_empty;

    sb_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head_data (pkt_if.pkt_data)
    );

endmodule : sb_rx_deser
`default_nettype wire

// File: tb/tb_sb_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sb_rx_deser
//  Description : Directed self-checking bench for sb_rx_deser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_rx_deser;
    import sb_pkg::*;

    logic clk;
    logic reset_n;
    logic sb_bit_vld;
    logic sb_bit;
    logic err_clr;
    logic err_framing;
    logic err_overflow;
    logic busy;

    int total;
    int bad;

    sb_rx_deser_if #(.PKT_W(SB_PKT_W)) pkt_if ();

    sb_rx_deser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sb_bit_vld   (sb_bit_vld),
        .sb_bit       (sb_bit),
        .pkt_if       (pkt_if),
        .err_framing  (err_framing),
        .err_overflow (err_overflow),
        .err_clr      (err_clr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one UI, let the DUT sample it, then settle 1ns past the edge
    task automatic send_bit(input logic v, input logic b);
        sb_bit_vld = v;
        sb_bit     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input sb_pkt_t d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(1'b1, d[i]);
        end
    endtask

    task automatic send_pkt(input sb_pkt_t d);
        send_bits(d, 0, SB_PKT_W - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b0, 1'b0);
        end
    endtask

    localparam sb_pkt_t PKT_1 = 64'hDEAD_BEEF_0123_4567;
    localparam sb_pkt_t PKT_A = 64'h0123_4567_89AB_CDEF;
    localparam sb_pkt_t PKT_B = 64'hFEDC_BA98_7654_3210;
    localparam sb_pkt_t PKT_C = 64'hA5A5_5A5A_F00F_0FF0;
    localparam sb_pkt_t PKT_X = 64'h1111_2222_3333_4444;
    localparam sb_pkt_t PKT_Y = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam sb_pkt_t PKT_Z = 64'h8000_0000_0000_0001;

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        sb_bit_vld  = 1'b0;
        sb_bit      = 1'b0;
        err_clr     = 1'b0;
        pkt_if.pkt_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(pkt_if.pkt_valid), 64'd0);
        chk("rst_data", pkt_if.pkt_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_errf", 64'(err_framing), 64'd0);
        chk("rst_erro", 64'(err_overflow), 64'd0);
        reset_n = 1'b1;
        idle(2);

        // ---------------- single packet ----------------
        pkt_if.pkt_ready = 1'b1;
        send_bits(PKT_1, 0, 62);
        chk("t1_valid_before_last", 64'(pkt_if.pkt_valid), 64'd0);
        chk("t1_busy_recv", 64'(busy), 64'd1);
        send_bits(PKT_1, 63, 63);
        chk("t1_valid", 64'(pkt_if.pkt_valid), 64'd1);
        chk("t1_data", pkt_if.pkt_data, PKT_1);
        chk("t1_errf", 64'(err_framing), 64'd0);
        idle(1);
        chk("t1_popped", 64'(pkt_if.pkt_valid), 64'd0);
        idle(30);
        chk("t1_busy_gap31", 64'(busy), 64'd1);
        idle(1);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        pkt_if.pkt_ready = 1'b0;

        // ---------------- back-to-back legal ----------------
        send_pkt(PKT_A);
        idle(32);
        send_pkt(PKT_B);
        chk("t2_errf", 64'(err_framing), 64'd0);
        chk("t2_head_a", pkt_if.pkt_data, PKT_A);
        pkt_if.pkt_ready = 1'b1;
        idle(1);
        chk("t2_head_b", pkt_if.pkt_data, PKT_B);
        chk("t2_valid_b", 64'(pkt_if.pkt_valid), 64'd1);
        idle(1);
        chk("t2_empty", 64'(pkt_if.pkt_valid), 64'd0);
        pkt_if.pkt_ready = 1'b0;
        idle(30);
        chk("t2_busy_idle", 64'(busy), 64'd0);

        // ---------------- gap violation ----------------
        send_pkt(PKT_A);
        idle(10);
        send_bits(PKT_C, 0, 0);
        chk("t3_errf_early", 64'(err_framing), 64'd1);
        send_bits(PKT_C, 1, 63);
        chk("t3_head_a", pkt_if.pkt_data, PKT_A);
        chk("t3_erro", 64'(err_overflow), 64'd0);
        pkt_if.pkt_ready = 1'b1;
        idle(1);
        chk("t3_head_c", pkt_if.pkt_data, PKT_C);
        idle(1);
        chk("t3_empty", 64'(pkt_if.pkt_valid), 64'd0);
        pkt_if.pkt_ready = 1'b0;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t3_errf_clr", 64'(err_framing), 64'd0);
        idle(29);
        chk("t3_busy_idle", 64'(busy), 64'd0);

        // ---------------- truncation ----------------
        send_bits(PKT_B, 0, 39);
        idle(1);
        chk("t4_errf", 64'(err_framing), 64'd1);
        chk("t4_no_push", 64'(pkt_if.pkt_valid), 64'd0);
        idle(30);
        chk("t4_busy_gap", 64'(busy), 64'd1);
        idle(1);
        chk("t4_busy_idle", 64'(busy), 64'd0);
        chk("t4_no_push_end", 64'(pkt_if.pkt_valid), 64'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t4_errf_clr", 64'(err_framing), 64'd0);

        // ---------------- set wins over clear ----------------
        pkt_if.pkt_ready = 1'b1;
        send_pkt(PKT_X);
        idle(5);
        send_bit(1'b1, 1'b1);
        chk("t5_errf_set", 64'(err_framing), 64'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t5_errf_setwins", 64'(err_framing), 64'd1);
        idle(31);
        chk("t5_busy_idle", 64'(busy), 64'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t5_errf_clr", 64'(err_framing), 64'd0);
        pkt_if.pkt_ready = 1'b0;

        // ---------------- overflow ----------------
        send_pkt(PKT_A);
        idle(32);
        send_pkt(PKT_B);
        chk("t6_erro_full", 64'(err_overflow), 64'd0);
        idle(32);
        send_pkt(PKT_C);
        chk("t6_erro", 64'(err_overflow), 64'd1);
        chk("t6_errf", 64'(err_framing), 64'd0);
        chk("t6_head_a", pkt_if.pkt_data, PKT_A);
        pkt_if.pkt_ready = 1'b1;
        idle(1);
        chk("t6_head_b", pkt_if.pkt_data, PKT_B);
        idle(1);
        chk("t6_empty", 64'(pkt_if.pkt_valid), 64'd0);
        pkt_if.pkt_ready = 1'b0;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t6_erro_clr", 64'(err_overflow), 64'd0);
        idle(29);
        chk("t6_busy_idle", 64'(busy), 64'd0);

        // ---------------- push and pop together while full ----------------
        send_pkt(PKT_A);
        idle(32);
        send_pkt(PKT_B);
        idle(32);
        send_bits(PKT_C, 0, 62);
        pkt_if.pkt_ready = 1'b1;
        send_bits(PKT_C, 63, 63);
        chk("t7_erro", 64'(err_overflow), 64'd0);
        chk("t7_head_b", pkt_if.pkt_data, PKT_B);
        idle(1);
        chk("t7_head_c", pkt_if.pkt_data, PKT_C);
        idle(1);
        chk("t7_empty", 64'(pkt_if.pkt_valid), 64'd0);
        pkt_if.pkt_ready = 1'b0;
        idle(30);

        // ---------------- reset mid-packet ----------------
        send_pkt(PKT_X);
        idle(32);
        send_bits(PKT_Y, 0, 29);
        reset_n = 1'b0;
        #1;
        chk("t8_rst_valid", 64'(pkt_if.pkt_valid), 64'd0);
        chk("t8_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(3);
        chk("t8_errf", 64'(err_framing), 64'd0);
        chk("t8_valid_idle", 64'(pkt_if.pkt_valid), 64'd0);
        send_pkt(PKT_Z);
        chk("t8_valid", 64'(pkt_if.pkt_valid), 64'd1);
        chk("t8_data", pkt_if.pkt_data, PKT_Z);
        chk("t8_erro", 64'(err_overflow), 64'd0);
        pkt_if.pkt_ready = 1'b1;
        idle(1);
        chk("t8_only_one", 64'(pkt_if.pkt_valid), 64'd0);
        chk("t8_errf_end", 64'(err_framing), 64'd0);
        pkt_if.pkt_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sb_rx_deser
`default_nettype wire

// File: doc/sb_rx_deser.md
Name: sb_rx_deser

Overview:
- Sideband receive deserializer; the receive-side counterpart of the sideband transmit serializer that drives the sb_txdata/sb_txclk driver tiles.
- Sits after the sb_rxdata/sb_rxclk receiver tiles in the PHY.
- Collects 64-bit sideband packets, LSB-first, and enforces the 32-UI minimum inter-packet gap.
- Presents packets to the link layer through a 2-entry valid/ready buffer, with sticky framing and overflow error flags.

Parameters:
- PKT_W, 64, packet width in bits / UIs per packet.
- GAP_UI, 32, minimum idle UIs required between packets.
- DEPTH, 2, output buffer entries; must be a power of 2.

Ports:
- clk  input  1  local sideband sample clock; one UI per cycle.
- reset_n  input  1  asynchronous active-low reset.
- sb_bit_vld  input  1  forwarded sideband clock toggled this UI; qualifies sb_bit.
- sb_bit  input  1  sampled sideband data bit.
- pkt_data  output  PKT_W  head-of-buffer packet.
- pkt_valid  output  1  buffer non-empty.
- pkt_ready  input  1  consumer accepts pkt_data when pkt_valid && pkt_ready.
- err_framing  output  1  sticky; gap violation or truncated packet.
- err_overflow  output  1  sticky; packet dropped because the buffer was full.
- err_clr  input  1  synchronous clear of both sticky flags.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Async reset (reset_n low): FSM=IDLE, bit counter=0, gap counter=0, buffer empty, pkt_valid=0, pkt_data=0, all error flags=0, busy=0.
- FSM states:
  - IDLE: on sb_bit_vld=1, shift sb_bit into shift-register bit 0, set bit_cnt=1, go to RECV.
  - RECV: each sb_bit_vld=1 cycle stores sb_bit at index bit_cnt and increments bit_cnt.
    - When the 64th bit is stored (bit_cnt==PKT_W-1 with vld), push the packet into the buffer, set gap_cnt=0, go to GAP.
    - sb_bit_vld=0 while in RECV (truncated packet): set err_framing, discard the partial packet, go to GAP with gap_cnt=1.
  - GAP: each sb_bit_vld=0 cycle increments gap_cnt (saturating at GAP_UI).
    - sb_bit_vld=1 with gap_cnt<GAP_UI: set err_framing, treat the bit as the first bit of a new packet (bit_cnt=1), go to RECV.
    - gap_cnt reaches GAP_UI: go to IDLE.
    - Back-to-back legal packet: the 33rd cycle after the last bit may carry vld and is handled by IDLE.
- Latency: pkt_valid rises the cycle after the 64th bit is sampled; pkt_data is bit i = i-th received UI (LSB first).
- Buffer: DEPTH-entry FIFO with wrapping read/write pointers and count.
  - Push when full: packet dropped, err_overflow set, buffer contents unchanged.
  - Push and pop in the same cycle while full: the pop occurs first, so the push succeeds and no overflow is flagged.
  - Pop only when pkt_valid && pkt_ready; pkt_ready while empty has no effect.
- Error flags:
  - Sticky until err_clr. err_clr takes effect the next cycle.
  - If err_clr coincides with a new error event, the flag stays set (set wins).
- busy = (state != IDLE).
- Reset asserted mid-packet or mid-gap: the partial packet is lost and the buffer is emptied. No error is flagged after release.

Decomposition:
- Package sb_pkg holds:
  - localparams SB_PKT_W=64 and SB_GAP_UI=32;
  - typedef sb_pkt_t (logic [63:0]);
  - enum sb_rx_state_e {IDLE, RECV, GAP}.
- One natural sub-module: sb_rx_fifo (parameterized DEPTH × PKT_W sync FIFO with push/pop/full/empty). The FSM, shift register and counters stay in sb_rx_deser.

Test Plan:
- Single packet: drive 64 vld bits of 64'hDEAD_BEEF_0123_4567 LSB-first with pkt_ready=1 → pkt_valid high one cycle after the 64th bit, pkt_data=64'hDEAD_BEEF_0123_4567, no errors, busy low 32 idle cycles later.
- Back-to-back legal: packet A, exactly 32 idle UIs, packet B, pkt_ready=0 → both buffered in order (A then B), err_framing=0.
- Gap violation: packet, then vld after only 10 idle UIs → err_framing=1. The new packet is still received and buffered when its 64 bits complete.
- Truncation: 40 vld bits, then vld=0 → err_framing=1, no packet pushed, FSM returns to IDLE after GAP_UI idle cycles.
- Overflow: 3 legal packets with pkt_ready=0 → first two retained, err_overflow=1. Then pop both → pkt_valid=0. Assert err_clr → flags clear next cycle.
- Reset mid-packet: reset_n low at bit 30, release, then send a full packet → only the post-reset packet appears, no error flags.
